avalon_gpio_port: RTL

- Parametrised Avalon-MM GPIO slave.
- Next generation of the single-register output PIO used for board LEDs; it replaces fixed-width output-only PIOs in the soc_simple systems.
- Provides per-bit direction, atomic set/clear, a synchronised input path, edge capture, and a maskable level interrupt to the CPU.
- Zero-wait-state slave on the system clock domain.

---
 rtl/gpio_pkg.sv | 16 +
 rtl/gpio_sync_edge.sv | 68 ++++++
 rtl/avalon_gpio_port.sv | 115 +++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the Avalon GPIO family: register offsets and
// edge-capture mode encodings.
package gpio_pkg;

  localparam logic [2:0] GPIO_DATA     = 3'd0;
  localparam logic [2:0] GPIO_DIR      = 3'd1;
  localparam logic [2:0] GPIO_IRQ_MASK = 3'd2;
  localparam logic [2:0] GPIO_EDGE_CAP = 3'd3;
  localparam logic [2:0] GPIO_OUTSET   = 3'd4;
  localparam logic [2:0] GPIO_OUTCLR   = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/gpio_sync_edge.sv
// Pin synchroniser with one-cycle history and edge detection. Edges are
// masked until the arm counter saturates after reset.
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] in_sync_o,
  output logic [WIDTH-1:0] edge_o
);

  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [2:0]                        arm_q;
  logic [2:0]                        arm_d;
  logic [WIDTH-1:0]                  rise_s;
  logic [WIDTH-1:0]                  fall_s;
  logic [WIDTH-1:0]                  sel_s;

  assign in_sync_o = sync_q[SYNC_STAGES-1];
  assign rise_s    = in_sync_o & ~prev_q;
  assign fall_s    = ~in_sync_o & prev_q;

  // Arm counter next state: count up once, then hold.
  always_comb begin
    if (arm_q == ARM_MAX) begin
      arm_d = arm_q;
    end else begin
      arm_d = arm_q + 3'd1;
    end
  end

  // Edge selection, gated until the synchroniser and history are primed.
  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISE: sel_s = rise_s;
      EDGE_FALL: sel_s = fall_s;
      EDGE_ANY:  sel_s = rise_s | fall_s;
      default:   sel_s = rise_s;
    endcase
    if (arm_q == ARM_MAX) begin
      edge_o = sel_s;
    end else begin
      edge_o = '0;
    end
  end

  // Synchroniser chain, history register and arm counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      arm_q  <= 3'd0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= in_sync_o;
      arm_q  <= arm_d;
    end
  end

endmodule

// File: rtl/avalon_gpio_port.sv
// Avalon-MM GPIO slave: data/direction registers, atomic set/clear,
// edge capture with maskable level interrupt, zero-wait-state reads.
module avalon_gpio_port
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  logic             wr_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] in_sync_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_mask_s;
  logic [WIDTH-1:0] rd_s;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q,      dir_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic             irq_q,      irq_d;

  assign wr_s    = chipselect & ~write_n;
  assign wdata_s = writedata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[31:WIDTH];
  end

  gpio_sync_edge #(
    .WIDTH      (WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .pin_i    (in_port),
    .in_sync_o(in_sync_s),
    .edge_o   (edge_s)
  );

  // Register file next state; a new edge wins over a same-cycle clear.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_mask_d = irq_mask_q;
    clr_mask_s = '0;
    if (wr_s) begin
      case (address)
        GPIO_DATA:     data_out_d = wdata_s;
        GPIO_DIR:      dir_d      = wdata_s;
        GPIO_IRQ_MASK: irq_mask_d = wdata_s;
        GPIO_EDGE_CAP: clr_mask_s = wdata_s;
        GPIO_OUTSET:   data_out_d = data_out_q | wdata_s;
        GPIO_OUTCLR:   data_out_d = data_out_q & ~wdata_s;
        default:       clr_mask_s = '0;
      endcase
    end else begin
      clr_mask_s = '0;
    end
    edge_cap_d = (edge_cap_q & ~clr_mask_s) | edge_s;
    irq_d      = |(edge_cap_q & irq_mask_q);
  end

  // Read mux: outputs read back the driven value, inputs the synchronised pin.
  always_comb begin
    case (address)
      GPIO_DATA:     rd_s = (dir_q & data_out_q) | (~dir_q & in_sync_s);
      GPIO_DIR:      rd_s = dir_q;
      GPIO_IRQ_MASK: rd_s = irq_mask_q;
      GPIO_EDGE_CAP: rd_s = edge_cap_q;
      default:       rd_s = '0;
    endcase
  end

  assign readdata = 32'(rd_s);

  // Register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= RESET_DIR;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      irq_q      <= irq_d;
    end
  end

  assign out_port = data_out_q;
  assign oe_port  = dir_q;
  assign irq      = irq_q;

endmodule
